// File: rtl/io_timer16.sv
// Memory-mapped 16-bit timer/counter on the split even/odd byte-lane I/O bus.
// It has a prescaled up-counter, compare match with optional auto-clear, an overflow flag and a level irq.
module io_timer16 #(
    parameter logic [15:0] BASEADDR = 16'h0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] read_addr_even,
    input  logic [14:0] read_addr_odd,
    input  logic [14:0] write_addr_even,
    input  logic [14:0] write_addr_odd,
    input  logic        write_en_even,
    input  logic        write_en_odd,
    input  logic [7:0]  write_data_even,
    input  logic [7:0]  write_data_odd,
    output logic [7:0]  read_data_even,
    output logic [7:0]  read_data_odd,
    output logic        irq
);

    // Bus protocol: there is no handshake. A lane performs a read in every cycle at its
    // read address, and that read's data appears on the following cycle. A lane performs
    // a write in any cycle its write_en is high. Both lanes are independent.
    localparam logic [12:0] WIN = BASEADDR[15:3];

    logic [15:0] cnt;
    logic [15:0] cmp;
    logic [6:0]  ctrl;
    logic        match;
    logic        ovf;
    logic [6:0]  pre;
    logic [7:0]  hi_shadow;

    logic        en;
    logic        autoclr;
    logic        irqen;
    logic [2:0]  ps;
    logic [6:0]  pre_limit;
    logic        tick;

    logic        rd_hit_even;
    logic        rd_hit_odd;
    logic        we_even;
    logic        we_odd;
    logic        wr_cnt_lo;
    logic        wr_cnt_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        wr_status;
    logic        cnt_wr;
    logic        shadow_load;
    logic        match_set;
    logic        ovf_set;
    logic [15:0] cnt_next;
    logic [7:0]  rd_mux_even;
    logic [7:0]  rd_mux_odd;

    assign en      = ctrl[0];
    assign autoclr = ctrl[1];
    assign irqen   = ctrl[2];
    assign ps      = ctrl[6:4];

    // The window is 8-byte aligned, so word address bits [1:0] select the register pair.
    assign rd_hit_even = (read_addr_even[14:2] == WIN);
    assign rd_hit_odd  = (read_addr_odd[14:2] == WIN);
    assign we_even     = write_en_even && (write_addr_even[14:2] == WIN);
    assign we_odd      = write_en_odd && (write_addr_odd[14:2] == WIN);

    assign wr_cnt_lo = we_even && (write_addr_even[1:0] == 2'd0);
    assign wr_cmp_lo = we_even && (write_addr_even[1:0] == 2'd1);
    assign wr_ctrl   = we_even && (write_addr_even[1:0] == 2'd2);
    assign wr_cnt_hi = we_odd && (write_addr_odd[1:0] == 2'd0);
    assign wr_cmp_hi = we_odd && (write_addr_odd[1:0] == 2'd1);
    assign wr_status = we_odd && (write_addr_odd[1:0] == 2'd2);
    assign cnt_wr    = wr_cnt_lo || wr_cnt_hi;

    assign shadow_load = rd_hit_even && (read_addr_even[1:0] == 2'd0);

    // 2^PS - 1 without a shifter on the compare path width.
    assign pre_limit = 7'h7F >> (3'd7 - ps);
    assign tick      = en && (pre == pre_limit);

    assign match_set = tick && !cnt_wr && (cnt == cmp);
    assign ovf_set   = tick && !cnt_wr && (cnt != cmp) && (cnt == 16'hFFFF);

    always_comb begin
        cnt_next = cnt;
        if (cnt_wr) begin
            if (wr_cnt_lo) cnt_next[7:0]  = write_data_even;
            if (wr_cnt_hi) cnt_next[15:8] = write_data_odd;
        end else if (tick) begin
            if ((cnt == cmp) && autoclr) cnt_next = 16'h0000;
            else                         cnt_next = cnt + 16'd1;
        end
    end

    always_comb begin
        rd_mux_even = 8'h00;
        if (rd_hit_even) begin
            case (read_addr_even[1:0])
                2'd0:    rd_mux_even = cnt[7:0];
                2'd1:    rd_mux_even = cmp[7:0];
                2'd2:    rd_mux_even = {1'b0, ctrl};
                default: rd_mux_even = 8'h00;
            endcase
        end
    end

    always_comb begin
        rd_mux_odd = 8'h00;
        if (rd_hit_odd) begin
            case (read_addr_odd[1:0])
                // Same-cycle low-byte read forwards the byte being captured into the shadow.
                2'd0:    rd_mux_odd = shadow_load ? cnt[15:8] : hi_shadow;
                2'd1:    rd_mux_odd = cmp[15:8];
                2'd2:    rd_mux_odd = {6'b0, ovf, match};
                default: rd_mux_odd = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= 16'h0000;
            cmp            <= 16'h0000;
            ctrl           <= 7'h00;
            match          <= 1'b0;
            ovf            <= 1'b0;
            pre            <= 7'h00;
            hi_shadow      <= 8'h00;
            read_data_even <= 8'h00;
            read_data_odd  <= 8'h00;
        end else begin
            cnt <= cnt_next;
            if (wr_cmp_lo) cmp[7:0]  <= write_data_even;
            if (wr_cmp_hi) cmp[15:8] <= write_data_odd;
            if (wr_ctrl)   ctrl      <= write_data_even[6:0];

            // Hardware set takes priority over a write-1-to-clear in the same cycle.
            match <= match_set || (match && !(wr_status && write_data_odd[0]));
            ovf   <= ovf_set   || (ovf   && !(wr_status && write_data_odd[1]));

            if (!en)       pre <= 7'h00;
            else if (tick) pre <= 7'h00;
            else           pre <= pre + 7'd1;

            if (shadow_load) hi_shadow <= cnt[15:8];

            read_data_even <= rd_mux_even;
            read_data_odd  <= rd_mux_odd;
        end
    end

    assign irq = irqen && (match || ovf);

endmodule

// File: tb/tb_io_timer16.sv
// Directed bench for io_timer16: register access, match/autoclear, overflow,
// prescaler, atomic high-byte shadow, set-vs-clear priority and async reset.
module tb_io_timer16;
    localparam logic [15:0] BASE = 16'h0010;
    localparam logic [14:0] PARK = 15'h4000;

    logic        clk;
    logic        reset;
    logic [14:0] read_addr_even;
    logic [14:0] read_addr_odd;
    logic [14:0] write_addr_even;
    logic [14:0] write_addr_odd;
    logic        write_en_even;
    logic        write_en_odd;
    logic [7:0]  write_data_even;
    logic [7:0]  write_data_odd;
    logic [7:0]  read_data_even;
    logic [7:0]  read_data_odd;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    io_timer16 #(.BASEADDR(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .read_addr_even  (read_addr_even),
        .read_addr_odd   (read_addr_odd),
        .write_addr_even (write_addr_even),
        .write_addr_odd  (write_addr_odd),
        .write_en_even   (write_en_even),
        .write_en_odd    (write_en_odd),
        .write_data_even (write_data_even),
        .write_data_odd  (write_data_odd),
        .read_data_even  (read_data_even),
        .read_data_odd   (read_data_odd),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        logic [15:0] a;
        a = BASE + {13'd0, off};
        if (off[0]) begin
            write_addr_odd = a[15:1];
            write_data_odd = d;
            write_en_odd   = 1'b1;
        end else begin
            write_addr_even = a[15:1];
            write_data_even = d;
            write_en_even   = 1'b1;
        end
        step(1);
        write_en_even = 1'b0;
        write_en_odd  = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] off, input logic [7:0] exp, input string tag);
        logic [15:0] a;
        logic [7:0]  d;
        a = BASE + {13'd0, off};
        if (off[0]) read_addr_odd  = a[15:1];
        else        read_addr_even = a[15:1];
        step(1);
        d = off[0] ? read_data_odd : read_data_even;
        read_addr_even = PARK;
        read_addr_odd  = PARK;
        check(tag, d, exp);
    endtask

    initial begin
        reset           = 1'b0;
        read_addr_even  = PARK;
        read_addr_odd   = PARK;
        write_addr_even = PARK;
        write_addr_odd  = PARK;
        write_en_even   = 1'b0;
        write_en_odd    = 1'b0;
        write_data_even = 8'h00;
        write_data_odd  = 8'h00;

        // Reset state
        step(3);
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_rde", read_data_even, 8'h00);
        reset = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++) rd_chk(3'(i), 8'h00, $sformatf("rst_reg%0d", i));
        check("rst_irq_after", {7'd0, irq}, 8'h00);

        // Match with autoclear, period 6 cycles
        wr(3'd2, 8'h05);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h07);
        check("irq_cnt0", {7'd0, irq}, 8'h00);
        step(5);
        check("irq_cnt5", {7'd0, irq}, 8'h00);
        step(1);
        check("irq_match", {7'd0, irq}, 8'h01);
        rd_chk(3'd0, 8'h00, "cnt_autoclr");
        wr(3'd5, 8'h01);
        check("irq_w1c", {7'd0, irq}, 8'h00);
        step(4);
        check("irq_repeat", {7'd0, irq}, 8'h01);
        wr(3'd5, 8'h01);
        check("irq_w1c2", {7'd0, irq}, 8'h00);
        step(4);
        wr(3'd5, 8'h01);
        check("set_wins_irq", {7'd0, irq}, 8'h01);
        rd_chk(3'd5, 8'h01, "set_wins_status");
        wr(3'd4, 8'h00);
        rd_chk(3'd0, 8'h02, "cnt_frozen");
        rd_chk(3'd0, 8'h02, "cnt_frozen2");
        rd_chk(3'd4, 8'h00, "ctrl_off");
        wr(3'd5, 8'h03);

        // Overflow without match
        wr(3'd0, 8'hFE);
        wr(3'd1, 8'hFF);
        wr(3'd2, 8'h34);
        wr(3'd3, 8'h12);
        wr(3'd4, 8'h01);
        step(2);
        check("ovf_irq_masked", {7'd0, irq}, 8'h00);
        rd_chk(3'd0, 8'h00, "ovf_wrap");
        rd_chk(3'd5, 8'h02, "ovf_flag");
        wr(3'd5, 8'h02);
        rd_chk(3'd5, 8'h00, "ovf_clr");
        rd_chk(3'd3, 8'h12, "cmp_hi_rb");
        wr(3'd4, 8'h00);

        // Prescaler PS=3: one tick per 8 cycles
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd4, 8'h31);
        step(7);
        rd_chk(3'd0, 8'h00, "ps3_before_tick");
        rd_chk(3'd0, 8'h01, "ps3_first_tick");
        step(71);
        rd_chk(3'd0, 8'h0A, "ps3_80cyc");
        wr(3'd4, 8'h00);

        // High-byte shadow
        wr(3'd0, 8'hFF);
        wr(3'd1, 8'h12);
        rd_chk(3'd0, 8'hFF, "shadow_lo");
        wr(3'd4, 8'h01);
        wr(3'd4, 8'h00);
        rd_chk(3'd1, 8'h12, "shadow_hi_held");
        rd_chk(3'd0, 8'h00, "cnt_lo_ticked");
        rd_chk(3'd1, 8'h13, "shadow_reload");
        wr(3'd0, 8'hFF);
        wr(3'd1, 8'h12);
        rd_chk(3'd1, 8'h13, "shadow_no_wr");
        read_addr_even = BASE[15:1];
        read_addr_odd  = BASE[15:1];
        step(1);
        check("pair_even", read_data_even, 8'hFF);
        check("pair_odd", read_data_odd, 8'h12);
        read_addr_even = 15'((BASE + 16'd8) >> 1);
        read_addr_odd  = 15'((BASE - 16'd8) >> 1);
        step(1);
        check("outside_even", read_data_even, 8'h00);
        check("outside_odd", read_data_odd, 8'h00);
        read_addr_even = PARK;
        read_addr_odd  = PARK;

        // Asynchronous reset while counting with irq high
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h07);
        step(1);
        check("pre_rst_irq", {7'd0, irq}, 8'h01);
        rd_chk(3'd4, 8'h07, "pre_rst_ctrl");
        reset = 1'b0;
        #1;
        check("async_rst_rde", read_data_even, 8'h00);
        check("async_rst_irq", {7'd0, irq}, 8'h00);
        step(2);
        reset = 1'b1;
        step(3);
        rd_chk(3'd4, 8'h00, "post_rst_ctrl");
        rd_chk(3'd0, 8'h00, "post_rst_cnt");
        rd_chk(3'd5, 8'h00, "post_rst_status");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
